// File: rtl/spu_pipe_pkg.sv
// Shared types and constants for the SPU pipeline registers.
package spu_pipe_pkg;

  localparam int unsigned SPU_DATA_W = 128;
  localparam int unsigned SPU_RT_W   = 7;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_we;
    logic mem_rd;
    logic mem_wr;
  } lane_ctrl_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  function automatic lane_ctrl_t gate_ctrl(input logic en, input lane_ctrl_t c);
    return en ? c : '0;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer: main register drives the output, skid catches
// the bundle accepted in the cycle in_ready drops.
module pipe_skid_buf
  import spu_pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
);

  skid_state_t          state;
  logic [PAYLOAD_W-1:0] main_q;
  logic [PAYLOAD_W-1:0] skid_q;
  logic                 push;
  logic                 pop;

  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign out_data = main_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      // A pop in this cycle has already been seen by MEM; any push is dropped.
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            main_q    <= in_data;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            skid_q   <= in_data;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (pop && !push) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end else if (push && pop) begin
            main_q <= in_data;
          end
        end
        FULL: begin
          if (pop) begin
            main_q   <= skid_q;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register: per-lane kill and control gating around a skid buffer.
// Optional perf counters enabled with EX_MEM_PERF_EN.
module ex_mem_pipe_reg
  import spu_pipe_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DATA_W = SPU_DATA_W,
  parameter int unsigned RT_W   = SPU_RT_W,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_lane_kill,
  input  logic [LANES-1:0]        in_mem_to_reg,
  input  logic [LANES-1:0]        in_reg_we,
  input  logic [LANES-1:0]        in_mem_rd,
  input  logic [LANES-1:0]        in_mem_wr,
  input  logic [LANES*DATA_W-1:0] in_result,
  input  logic [LANES*DATA_W-1:0] in_rc_data,
  input  logic [LANES*RT_W-1:0]   in_rt_addr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_lane_valid,
  output logic [LANES-1:0]        out_mem_to_reg,
  output logic [LANES-1:0]        out_reg_we,
  output logic [LANES-1:0]        out_mem_rd,
  output logic [LANES-1:0]        out_mem_wr,
  output logic [LANES*DATA_W-1:0] out_result,
  output logic [LANES*DATA_W-1:0] out_rc_data,
  output logic [LANES*RT_W-1:0]   out_rt_addr
`ifdef EX_MEM_PERF_EN
  ,
  output logic [CNT_W-1:0]        perf_stall_cnt,
  output logic [CNT_W-1:0]        perf_flush_cnt
`endif
);

  localparam int unsigned LANE_W    = 1 + $bits(lane_ctrl_t) + 2 * DATA_W + RT_W;
  localparam int unsigned PAYLOAD_W = LANES * LANE_W;

  logic [PAYLOAD_W-1:0] in_pack;
  logic [PAYLOAD_W-1:0] out_pack;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_ctrl_t        in_ctrl;
    lane_ctrl_t        st_ctrl;
    lane_ctrl_t        gated;
    logic              st_lv;
    logic [DATA_W-1:0] st_res;
    logic [DATA_W-1:0] st_rc;
    logic [RT_W-1:0]   st_rt;

    assign in_ctrl = '{mem_to_reg: in_mem_to_reg[i], reg_we: in_reg_we[i],
                       mem_rd: in_mem_rd[i], mem_wr: in_mem_wr[i]};

    assign in_pack[i*LANE_W +: LANE_W] = {~in_lane_kill[i], in_ctrl,
                                          in_result[i*DATA_W +: DATA_W],
                                          in_rc_data[i*DATA_W +: DATA_W],
                                          in_rt_addr[i*RT_W +: RT_W]};

    assign {st_lv, st_ctrl, st_res, st_rc, st_rt} = out_pack[i*LANE_W +: LANE_W];

    assign gated = gate_ctrl(out_valid & st_lv, st_ctrl);

    assign out_lane_valid[i]              = st_lv;
    assign out_mem_to_reg[i]              = gated.mem_to_reg;
    assign out_reg_we[i]                  = gated.reg_we;
    assign out_mem_rd[i]                  = gated.mem_rd;
    assign out_mem_wr[i]                  = gated.mem_wr;
    assign out_result[i*DATA_W +: DATA_W] = st_res;
    assign out_rc_data[i*DATA_W +: DATA_W] = st_rc;
    assign out_rt_addr[i*RT_W +: RT_W]    = st_rt;
  end

  pipe_skid_buf #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pack)
  );

`ifdef EX_MEM_PERF_EN
  // out_valid is high exactly when the buffer state is not EMPTY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      if (flush && out_valid && perf_flush_cnt != '1)
        perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench for ex_mem_pipe_reg: vector table plus queue scoreboard.
module tb_ex_mem_pipe_reg;
  import spu_pipe_pkg::*;

  localparam int L  = 2;
  localparam int DW = 128;
  localparam int RW = 7;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [L-1:0] in_lane_kill, in_mem_to_reg, in_reg_we, in_mem_rd, in_mem_wr;
  logic [L*DW-1:0] in_result, in_rc_data, out_result, out_rc_data;
  logic [L*RW-1:0] in_rt_addr, out_rt_addr;
  logic [L-1:0] out_lane_valid, out_mem_to_reg, out_reg_we, out_mem_rd, out_mem_wr;
`ifdef EX_MEM_PERF_EN
  logic [CW-1:0] perf_stall_cnt, perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  ex_mem_pipe_reg #(.LANES(L), .DATA_W(DW), .RT_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_kill(in_lane_kill), .in_mem_to_reg(in_mem_to_reg), .in_reg_we(in_reg_we),
    .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr), .in_result(in_result),
    .in_rc_data(in_rc_data), .in_rt_addr(in_rt_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_lane_valid(out_lane_valid), .out_mem_to_reg(out_mem_to_reg),
    .out_reg_we(out_reg_we), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
    .out_result(out_result), .out_rc_data(out_rc_data), .out_rt_addr(out_rt_addr)
`ifdef EX_MEM_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  typedef struct {
    bit v, ordy, fl;
    logic [L-1:0] kill, we, wr;
    int tag;
    bit eov, eir;
  } vec_t;

  typedef struct {
    logic [L*DW-1:0] res, rc;
    logic [L*RW-1:0] rt;
    logic [L-1:0] lv, mtr, we, rd, wr;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [L*DW-1:0] act, input logic [L*DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [L*DW-1:0] mk_res(input int tag);
    logic [L*DW-1:0] r;
    for (int i = 0; i < L; i++) r[i*DW +: DW] = {8{16'(tag * 4 + i)}};
    return r;
  endfunction

  function automatic logic [L*RW-1:0] mk_rt(input int tag);
    logic [L*RW-1:0] r;
    for (int i = 0; i < L; i++) r[i*RW +: RW] = 7'(tag * 3 + i + 1);
    return r;
  endfunction

  function automatic vec_t V(input bit v, ordy, fl, input logic [L-1:0] kill, we, wr,
                             input int tag, input bit eov, eir);
    vec_t t;
    t.v = v; t.ordy = ordy; t.fl = fl; t.kill = kill; t.we = we; t.wr = wr;
    t.tag = tag; t.eov = eov; t.eir = eir;
    return t;
  endfunction

  // Drive one cycle's inputs, check outputs against the queue model, advance the model.
  task automatic step(input vec_t t, input bit has_exp);
    exp_t e;
    bit push, pop;
    in_valid = t.v; out_ready = t.ordy; flush = t.fl; in_lane_kill = t.kill;
    in_reg_we = t.we; in_mem_wr = t.wr;
    in_mem_to_reg = 2'(t.tag); in_mem_rd = 2'(t.tag >> 1);
    in_result = mk_res(t.tag); in_rc_data = ~mk_res(t.tag); in_rt_addr = mk_rt(t.tag);
    #1;
    if (has_exp) begin
      chk("tbl_out_valid", out_valid, t.eov);
      chk("tbl_in_ready", in_ready, t.eir);
    end
    chk("out_valid", out_valid, sb.size() > 0);
    chk("in_ready", in_ready, sb.size() < 2);
    if (sb.size() > 0) begin
      e = sb[0];
      chk("lane_valid", out_lane_valid, e.lv);
      chk("mem_to_reg", out_mem_to_reg, e.mtr);
      chk("reg_we", out_reg_we, e.we);
      chk("mem_rd", out_mem_rd, e.rd);
      chk("mem_wr", out_mem_wr, e.wr);
      chk("result", out_result, e.res);
      chk("rc_data", out_rc_data, e.rc);
      chk("rt_addr", out_rt_addr, e.rt);
    end else begin
      chk("gated_idle", {out_mem_to_reg, out_reg_we, out_mem_rd, out_mem_wr}, '0);
    end
    pop  = (sb.size() > 0) && t.ordy;
    push = t.v && (sb.size() < 2);
    if (pop) void'(sb.pop_front());
    if (t.fl) sb.delete();
    else if (push) begin
      e.lv = ~t.kill;
      e.mtr = e.lv & 2'(t.tag); e.we = e.lv & t.we;
      e.rd = e.lv & 2'(t.tag >> 1); e.wr = e.lv & t.wr;
      e.res = mk_res(t.tag); e.rc = ~mk_res(t.tag); e.rt = mk_rt(t.tag);
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    step(V(0, ordy, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0), 0);
  endtask

  initial begin
    reset = 1'b0; flush = 0; in_valid = 0; out_ready = 0; in_lane_kill = '0;
    in_mem_to_reg = '0; in_reg_we = '0; in_mem_rd = '0; in_mem_wr = '0;
    in_result = '0; in_rc_data = '0; in_rt_addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // streaming
    tbl.push_back(V(1,1,0,2'b00,2'b11,2'b00, 1,0,1));
    tbl.push_back(V(1,1,0,2'b00,2'b01,2'b10, 2,1,1));
    tbl.push_back(V(1,1,0,2'b00,2'b10,2'b01, 3,1,1));
    tbl.push_back(V(0,1,0,2'b00,2'b00,2'b00, 0,1,1));
    tbl.push_back(V(0,1,0,2'b00,2'b00,2'b00, 0,0,1));
    // kill / all-killed bundle
    tbl.push_back(V(1,1,0,2'b01,2'b11,2'b11, 4,0,1));
    tbl.push_back(V(1,1,0,2'b11,2'b11,2'b11, 5,1,1));
    tbl.push_back(V(0,1,0,2'b00,2'b00,2'b00, 0,1,1));
    tbl.push_back(V(0,1,0,2'b00,2'b00,2'b00, 0,0,1));
    // backpressure
    tbl.push_back(V(1,0,0,2'b00,2'b11,2'b01, 6,0,1));
    tbl.push_back(V(1,0,0,2'b00,2'b01,2'b11, 7,1,1));
    tbl.push_back(V(1,0,0,2'b00,2'b11,2'b11, 8,1,0));
    tbl.push_back(V(0,0,0,2'b00,2'b00,2'b00, 0,1,0));
    tbl.push_back(V(0,0,0,2'b00,2'b00,2'b00, 0,1,0));
    tbl.push_back(V(0,1,0,2'b00,2'b00,2'b00, 0,1,0));
    tbl.push_back(V(0,1,0,2'b00,2'b00,2'b00, 0,1,1));
    tbl.push_back(V(0,1,0,2'b00,2'b00,2'b00, 0,0,1));
    // flush while FULL, while ONE with pop, while EMPTY
    tbl.push_back(V(1,0,0,2'b00,2'b11,2'b00, 9,0,1));
    tbl.push_back(V(1,0,0,2'b00,2'b00,2'b11,10,1,1));
    tbl.push_back(V(1,0,1,2'b00,2'b11,2'b11,11,1,0));
    tbl.push_back(V(0,1,0,2'b00,2'b00,2'b00, 0,0,1));
    tbl.push_back(V(1,0,0,2'b10,2'b11,2'b11,12,0,1));
    tbl.push_back(V(1,1,1,2'b00,2'b11,2'b11,13,1,1));
    tbl.push_back(V(0,1,0,2'b00,2'b00,2'b00, 0,0,1));
    tbl.push_back(V(1,1,1,2'b00,2'b11,2'b11,14,0,1));
    tbl.push_back(V(0,1,0,2'b00,2'b00,2'b00, 0,0,1));

    foreach (tbl[k]) step(tbl[k], 1);

    // asynchronous reset while FULL
    step(V(1,0,0,2'b00,2'b11,2'b11,20,0,0), 0);
    step(V(1,0,0,2'b00,2'b11,2'b11,21,0,0), 0);
    #2 reset = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_lane_valid", out_lane_valid, '0);
    chk("rst_ctrl", {out_mem_to_reg, out_reg_we, out_mem_rd, out_mem_wr}, '0);
    chk("rst_result", out_result, '0);
    chk("rst_rc_data", out_rc_data, '0);
    chk("rst_rt_addr", out_rt_addr, '0);
    sb.delete();
    in_valid = 0;
    @(negedge clk);
    reset = 1'b1;
    idle(1);

`ifdef EX_MEM_PERF_EN
    reset = 1'b0; #1; reset = 1'b1;
    @(negedge clk);
    chk("perf_rst", {perf_stall_cnt, perf_flush_cnt}, '0);
    step(V(1,0,0,2'b00,2'b11,2'b11,30,0,0), 0);
    repeat (4) idle(0);
    step(V(0,1,1,2'b00,2'b00,2'b00,0,0,0), 0);
    chk("perf_stall4", perf_stall_cnt, 4);
    chk("perf_flush1", perf_flush_cnt, 1);
    step(V(1,0,0,2'b00,2'b11,2'b11,31,0,0), 0);
    repeat (20) idle(0);
    chk("perf_stall_sat", perf_stall_cnt, 15);
    idle(1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
